// File: rtl/reg_access_master_if.sv
// Request/response handshake plus register-set strobe bus for reg_access_master.
// master modport: the initiator (reg_access_master); slave modport: the
// command source, the response consumer and the register-set responder.
interface reg_access_master_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    input  req_valid, req_op, req_addr, req_wdata, rsp_ready, rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, wr_en, rd_en, addr, wdata
  );

  modport slave (
    output req_valid, req_op, req_addr, req_wdata, rsp_ready, rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, wr_en, rd_en, addr, wdata
  );
endinterface

// File: rtl/reg_access_master.sv
// Register-set bus initiator: one request at a time, strobe sequencing toward
// the register set, read-data capture and a held response.
// Optional feature macro: REG_MASTER_RMW_EN enables read-modify-write
// (op 10 set bits, op 11 clear bits). Without it those ops are answered with
// an error response and no bus access.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// READ  | rd_en high for one cycle, rdata captured at the end of the cycle
// WRITE | wr_en high for one cycle (plain write or RMW write-back)
// RSP   | rsp_valid high, response held until rsp_ready
module reg_access_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_access_master_if.master  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RSP} state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;

  state_t            state_q, state_nxt;
  logic              wr_en_q, wr_en_nxt;
  logic              rd_en_q, rd_en_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic              rsp_valid_q, rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_nxt;
  logic              rsp_err_q, rsp_err_nxt;
  logic              req_err;

`ifdef REG_MASTER_RMW_EN
  // op_q[1] marks an RMW, op_q[0] selects clear (1) versus set (0)
  logic [1:0]        op_q, op_nxt;
  logic [DATA_W-1:0] mask_q, mask_nxt;
`endif

  // Misaligned addresses are always rejected; RMW ops only when compiled out.
`ifdef REG_MASTER_RMW_EN
  assign req_err = (bus.req_addr[1:0] != 2'b00);
`else
  assign req_err = (bus.req_addr[1:0] != 2'b00) || bus.req_op[1];
`endif

  // Next state and next registered output values.
  always_comb begin
    state_nxt     = state_q;
    wr_en_nxt     = 1'b0;
    rd_en_nxt     = 1'b0;
    addr_nxt      = addr_q;
    wdata_nxt     = wdata_q;
    rsp_valid_nxt = rsp_valid_q;
    rsp_rdata_nxt = rsp_rdata_q;
    rsp_err_nxt   = rsp_err_q;
`ifdef REG_MASTER_RMW_EN
    op_nxt        = op_q;
    mask_nxt      = mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b0;
`ifdef REG_MASTER_RMW_EN
          op_nxt        = bus.req_op;
          mask_nxt      = bus.req_wdata;
`endif
          if (req_err) begin
            state_nxt     = RSP;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
          end else if (bus.req_op == OP_WRITE) begin
            state_nxt = WRITE;
            wr_en_nxt = 1'b1;
            addr_nxt  = bus.req_addr;
            wdata_nxt = bus.req_wdata;
          end else begin
            state_nxt = READ;
            rd_en_nxt = 1'b1;
            addr_nxt  = bus.req_addr;
          end
        end
      end
      READ: begin
        rsp_rdata_nxt = bus.rdata;
`ifdef REG_MASTER_RMW_EN
        if (op_q[1]) begin
          state_nxt = WRITE;
          wr_en_nxt = 1'b1;
          wdata_nxt = op_q[0] ? (bus.rdata & ~mask_q) : (bus.rdata | mask_q);
        end else begin
          state_nxt     = RSP;
          rsp_valid_nxt = 1'b1;
        end
`else
        state_nxt     = RSP;
        rsp_valid_nxt = 1'b1;
`endif
      end
      WRITE: begin
        state_nxt     = RSP;
        rsp_valid_nxt = 1'b1;
      end
      RSP: begin
        if (bus.rsp_ready) begin
          state_nxt     = IDLE;
          rsp_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset drops strobes and discards any request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef REG_MASTER_RMW_EN
      op_q        <= 2'b00;
      mask_q      <= '0;
`endif
    end else begin
      state_q     <= state_nxt;
      wr_en_q     <= wr_en_nxt;
      rd_en_q     <= rd_en_nxt;
      addr_q      <= addr_nxt;
      wdata_q     <= wdata_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_rdata_q <= rsp_rdata_nxt;
      rsp_err_q   <= rsp_err_nxt;
`ifdef REG_MASTER_RMW_EN
      op_q        <= op_nxt;
      mask_q      <= mask_nxt;
`endif
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.wr_en     = wr_en_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_reg_access_master.sv
// Directed bench for reg_access_master with a small register-set responder.
module tb_reg_access_master;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   cnt_wr;
  int   cnt_rd;
  logic overlap;
  int   w0;
  int   r0;
  logic [31:0] regs [256];

  reg_access_master_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  reg_access_master #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: combinational read data, write on strobe.
  assign bus.rdata = regs[bus.addr[9:2]];

  always @(posedge clk) begin
    if (bus.wr_en) regs[bus.addr[9:2]] <= bus.wdata;
    if (bus.wr_en) cnt_wr <= cnt_wr + 1;
    if (bus.rd_en) cnt_rd <= cnt_rd + 1;
    if (bus.wr_en && bus.rd_en) overlap <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request for one cycle; returns mid-cycle N+1.
  task automatic issue(input logic [1:0] op, input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_wdata = d;
    chk("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Consume the response currently presented; returns mid-cycle after it.
  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("req_ready_after_rsp", 32'(bus.req_ready), 32'd1);
    chk("rsp_valid_after_rsp", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    n_chk = 0; n_err = 0; cnt_wr = 0; cnt_rd = 0; overlap = 1'b0;
    for (int i = 0; i < 256; i++) regs[i] = 32'h0;
    regs[1] = 32'hDEADBEEF;
    regs[2] = 32'h12345601;
    regs[3] = 32'h12345601;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
    chk("rst_addr", 32'(bus.addr), 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);

    // Write 0xDEADBEEF to 0x000
    w0 = cnt_wr;
    issue(2'b00, 10'h000, 32'hDEADBEEF);
    chk("wr_wr_en_n1", 32'(bus.wr_en), 32'd1);
    chk("wr_rd_en_n1", 32'(bus.rd_en), 32'd0);
    chk("wr_addr_n1", 32'(bus.addr), 32'h000);
    chk("wr_wdata_n1", bus.wdata, 32'hDEADBEEF);
    chk("wr_rsp_valid_n1", 32'(bus.rsp_valid), 32'd0);
    chk("wr_req_ready_n1", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk("wr_wr_en_n2", 32'(bus.wr_en), 32'd0);
    chk("wr_rsp_valid_n2", 32'(bus.rsp_valid), 32'd1);
    chk("wr_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("wr_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("wr_wdata_hold", bus.wdata, 32'hDEADBEEF);
    consume();
    chk("wr_strobe_count", 32'(cnt_wr - w0), 32'd1);
    chk("wr_mem", regs[0], 32'hDEADBEEF);

    // Read 0x004, response stalled for 5 cycles
    r0 = cnt_rd;
    issue(2'b01, 10'h004, 32'h0);
    chk("rd_rd_en_n1", 32'(bus.rd_en), 32'd1);
    chk("rd_wr_en_n1", 32'(bus.wr_en), 32'd0);
    chk("rd_addr_n1", 32'(bus.addr), 32'h004);
    @(negedge clk);
    chk("rd_rd_en_n2", 32'(bus.rd_en), 32'd0);
    chk("rd_rsp_valid_n2", 32'(bus.rsp_valid), 32'd1);
    chk("rd_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    chk("rd_rsp_err", 32'(bus.rsp_err), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_rsp_rdata", bus.rsp_rdata, 32'hDEADBEEF);
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end
    consume();
    chk("rd_strobe_count", 32'(cnt_rd - r0), 32'd1);

`ifdef REG_MASTER_RMW_EN
    // RMW set 0xF0 on 0x12345601 at 0x008
    w0 = cnt_wr; r0 = cnt_rd;
    issue(2'b10, 10'h008, 32'h000000F0);
    chk("set_rd_en_n1", 32'(bus.rd_en), 32'd1);
    chk("set_wr_en_n1", 32'(bus.wr_en), 32'd0);
    @(negedge clk);
    chk("set_wr_en_n2", 32'(bus.wr_en), 32'd1);
    chk("set_rd_en_n2", 32'(bus.rd_en), 32'd0);
    chk("set_wdata", bus.wdata, 32'h123456F1);
    chk("set_addr", 32'(bus.addr), 32'h008);
    chk("set_rsp_valid_n2", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("set_rsp_valid_n3", 32'(bus.rsp_valid), 32'd1);
    chk("set_rsp_rdata", bus.rsp_rdata, 32'h12345601);
    chk("set_rsp_err", 32'(bus.rsp_err), 32'd0);
    consume();
    chk("set_mem", regs[2], 32'h123456F1);

    // RMW clear 0xFF000000 on 0x12345601 at 0x00C
    issue(2'b11, 10'h00C, 32'hFF000000);
    chk("clr_rd_en_n1", 32'(bus.rd_en), 32'd1);
    @(negedge clk);
    chk("clr_wr_en_n2", 32'(bus.wr_en), 32'd1);
    chk("clr_wdata", bus.wdata, 32'h00345601);
    @(negedge clk);
    chk("clr_rsp_rdata", bus.rsp_rdata, 32'h12345601);
    consume();
    chk("rmw_wr_count", 32'(cnt_wr - w0), 32'd2);
    chk("rmw_rd_count", 32'(cnt_rd - r0), 32'd2);
`else
    // RMW ops rejected when compiled out
    w0 = cnt_wr; r0 = cnt_rd;
    issue(2'b10, 10'h008, 32'h000000F0);
    chk("set_err_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("set_err_rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("set_err_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("set_err_rd_en", 32'(bus.rd_en), 32'd0);
    consume();
    issue(2'b11, 10'h00C, 32'hFF000000);
    chk("clr_err_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("clr_err_rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("clr_err_rsp_rdata", bus.rsp_rdata, 32'd0);
    consume();
    chk("rmw_off_wr_count", 32'(cnt_wr - w0), 32'd0);
    chk("rmw_off_rd_count", 32'(cnt_rd - r0), 32'd0);
    chk("rmw_off_mem", regs[2], 32'h12345601);
`endif

    // Misaligned read at 0x006
    w0 = cnt_wr; r0 = cnt_rd;
    issue(2'b01, 10'h006, 32'h0);
    chk("mis_rsp_valid_n1", 32'(bus.rsp_valid), 32'd1);
    chk("mis_rsp_err", 32'(bus.rsp_err), 32'd1);
    chk("mis_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("mis_rd_en", 32'(bus.rd_en), 32'd0);
    repeat (2) @(negedge clk);
    chk("mis_rsp_err_hold", 32'(bus.rsp_err), 32'd1);
    consume();
    chk("mis_wr_count", 32'(cnt_wr - w0), 32'd0);
    chk("mis_rd_count", 32'(cnt_rd - r0), 32'd0);

    // Reset pulsed during the read cycle of an RMW (plain read without RMW)
    w0 = cnt_wr;
`ifdef REG_MASTER_RMW_EN
    issue(2'b10, 10'h010, 32'h0000000F);
`else
    issue(2'b01, 10'h010, 32'h0);
`endif
    chk("rstmid_rd_en_before", 32'(bus.rd_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_rd_en_async", 32'(bus.rd_en), 32'd0);
    chk("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (3) @(negedge clk);
    chk("rstmid_no_wr", 32'(cnt_wr - w0), 32'd0);
    chk("rstmid_rsp_valid_after", 32'(bus.rsp_valid), 32'd0);
    chk("rstmid_mem", regs[4], 32'h0);

    chk("strobe_overlap", 32'(overlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
